hazard_ctrl: RTL

- Pipeline hazard controller: it generates the flush and stall controls that the decode/execute and fetch/decode pipeline registers consume.
- It compares decode-stage source registers against the destinations of instructions in execute, memory and writeback.
- Outputs: load-use stalls, taken-branch flushes (with a multi-cycle redirect window) and execute-stage forwarding selects.
- Also keeps saturating stall/flush event counters for debug.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 59 +++++
 rtl/hazard_ctrl_sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the pipeline hazard controller.
//   fwd_sel_t     : execute-stage operand source select
//                   (register file, writeback result, memory-stage result)
//   redir_state_t : redirect window state machine encoding
// ----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } redir_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   Inputs to the controller : decode sources/uses, execute sources and
//                              destination info, memory/writeback destinations,
//                              taken-redirect strobe.
//   Outputs of the controller: stall/flush controls, forwarding selects,
//                              debug event counters and redirect-busy flag.
//   master : pipeline side (drives hazard inputs, consumes controls)
//   slave  : hazard controller
// ----------------------------------------------------------------------------
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int M     = 4,
   parameter int CNT_W = 16
);
   logic [M-1:0]     srcA_D;
   logic [M-1:0]     srcB_D;
   logic             useA_D;
   logic             useB_D;
   logic [M-1:0]     srcA_E;
   logic [M-1:0]     srcB_E;
   logic [M-1:0]     regScr_E;
   logic             regw_E;
   logic             regmem_E;
   logic             pcload_E;
   logic [M-1:0]     regScr_M;
   logic             regw_M;
   logic [M-1:0]     regScr_W;
   logic             regw_W;

   logic             stall_F;
   logic             stall_D;
   logic             flush_D;
   logic             flush_E;
   fwd_sel_t         fwdA_E;
   fwd_sel_t         fwdB_E;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             busy;

   modport master (
      output srcA_D, srcB_D, useA_D, useB_D,
      output srcA_E, srcB_E, regScr_E, regw_E, regmem_E, pcload_E,
      output regScr_M, regw_M, regScr_W, regw_W,
      input  stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E,
      input  stall_cnt, flush_cnt, busy
   );

   modport slave (
      input  srcA_D, srcB_D, useA_D, useB_D,
      input  srcA_E, srcB_E, regScr_E, regw_E, regmem_E, pcload_E,
      input  regScr_M, regw_M, regScr_W, regw_W,
      output stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E,
      output stall_cnt, flush_cnt, busy
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Event counter that saturates at all-ones and holds until reset.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears count)
//   inc   : count one event this cycle
//   count : current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller: load-use stall, taken-redirect flush with a
//   FLUSH_CYC-cycle flush_D window, execute-stage forwarding selects and
//   saturating debug counters.
//   clk : clock
//   rst : asynchronous active-low reset
//   hz  : hazard interface (slave side), see hazard_ctrl_if
// All controls are combinational (zero-cycle response); only the redirect
// window state, busy and the counters are registered.
// ----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int M         = 4,
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   // Window counter only needs to hold FLUSH_CYC-1.
   localparam int WIN_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   redir_state_t     state_reg;
   logic [WIN_W-1:0] win_cnt_reg;
   logic             busy_reg;

   logic lu;
   logic redir_take;
   logic in_redir;
   logic stall;

   // Load-use: every index compares, register 0 included.
   assign lu = hz.regw_E & hz.regmem_E &
               ((hz.useA_D & (hz.srcA_D == hz.regScr_E)) |
                (hz.useB_D & (hz.srcB_D == hz.regScr_E)));

   assign redir_take = (state_reg == IDLE) & hz.pcload_E;
   assign in_redir   = (state_reg == REDIR);

   // A taken redirect wins over load-use: the stalled instruction is on the
   // wrong path. Gated by rst so reset never shows a stall.
   assign stall = lu & ~redir_take & ~in_redir & rst;

   assign hz.stall_F = stall;
   assign hz.stall_D = stall;
   assign hz.flush_D = redir_take | in_redir | ~rst;
   assign hz.flush_E = redir_take | stall | ~rst;
   assign hz.busy    = busy_reg;

   // Redirect window FSM. pcload_E in REDIR is deliberately ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         win_cnt_reg <= '0;
         busy_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (hz.pcload_E && (FLUSH_CYC > 1)) begin
                  state_reg   <= REDIR;
                  win_cnt_reg <= WIN_W'(FLUSH_CYC - 1);
                  busy_reg    <= 1'b1;
               end
            end
            REDIR: begin
               win_cnt_reg <= win_cnt_reg - 1'b1;
               if (win_cnt_reg == WIN_W'(1)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg   <= IDLE;
               win_cnt_reg <= '0;
               busy_reg    <= 1'b0;
            end
         endcase
      end
   end

   // Forwarding: memory stage holds the newer value, so it has priority.
   logic [M-1:0] src_e [2];
   fwd_sel_t     fwd_e [2];

   assign src_e[0] = hz.srcA_E;
   assign src_e[1] = hz.srcB_E;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         always_comb begin
            fwd_e[gi] = FWD_RF;
            if (rst) begin
               if (hz.regw_M && (hz.regScr_M == src_e[gi])) begin
                  fwd_e[gi] = FWD_M;
               end else if (hz.regw_W && (hz.regScr_W == src_e[gi])) begin
                  fwd_e[gi] = FWD_W;
               end
            end
         end
      end
   endgenerate

   assign hz.fwdA_E = fwd_e[0];
   assign hz.fwdB_E = fwd_e[1];

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redir_take),
      .count (hz.flush_cnt)
   );

endmodule
